data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/data_memory_pkg.sv | 25 ++
 rtl/data_memory_load_extend.sv | 45 ++++
 rtl/data_memory.sv | 95 +++++++++
 tb/tb_data_memory.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// Shared instruction definitions for the data memory: RISC-V load/store
// funct3 encodings and the funct3 field width.
package data_memory_pkg;

  localparam int unsigned FUNCT_3_W = 3;
  typedef logic [FUNCT_3_W-1:0] funct3_t;

  // Load encodings
  localparam funct3_t LB  = 3'b000;
  localparam funct3_t LH  = 3'b001;
  localparam funct3_t LW  = 3'b010;
  localparam funct3_t LBU = 3'b100;
  localparam funct3_t LHU = 3'b101;

  // Store encodings
  localparam funct3_t SB  = 3'b000;
  localparam funct3_t SH  = 3'b001;
  localparam funct3_t SW  = 3'b010;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned LANES     = WORD_W / BYTE_W;
  localparam int unsigned LANE_IDX_W = 2;

endpackage

// File: rtl/data_memory_load_extend.sv
// load_extend: picks the byte/halfword/word lane out of a memory word and
// sign- or zero-extends it to 32 bits according to the load funct3.
// Ports:
//   word     - full 32-bit word read from memory
//   byte_off - addr[1:0] of the load
//   funct3   - load funct3 (LB/LH/LW/LBU/LHU; anything else gives 0)
//   result_c - extended 32-bit load value (combinational)
module load_extend
  import data_memory_pkg::*;
(
  input  logic [WORD_W-1:0]     word,
  input  logic [LANE_IDX_W-1:0] byte_off,
  input  funct3_t               funct3,
  output logic [WORD_W-1:0]     result_c
);

  logic [BYTE_W-1:0]   byte_sel;
  logic [2*BYTE_W-1:0] half_sel;

  // Lane selection
  always_comb begin
    byte_sel = '0;
    case (byte_off)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = byte_off[1] ? word[31:16] : word[15:0];
  end

  // Extension; unsupported encodings return zero
  always_comb begin
    result_c = '0;
    case (funct3)
      LB:      result_c = {{24{byte_sel[7]}}, byte_sel};
      LH:      result_c = {{16{half_sel[15]}}, half_sel};
      LW:      result_c = word;
      LBU:     result_c = {24'd0, byte_sel};
      LHU:     result_c = {16'd0, half_sel};
      default: result_c = '0;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// data_memory: byte-lane writable word memory with RISC-V load/store
// semantics and a registered, 1-cycle-latency load result.
// Ports:
//   clk      - clock, all state on rising edge
//   rst      - synchronous active-high reset (clears data_out, blocks stores)
//   wr_en    - 1 = store cycle, 0 = load cycle
//   funct3   - RISC-V load/store funct3
//   addr     - byte address; [LOGSIZE+1:2] word, [1:0] byte lane
//   data_in  - store data (low-order bits used for SB/SH)
//   data_out - registered load result
// Configuration macro: DMEM_ZERO_INIT_EN -- when defined, reset also clears
// every memory word; otherwise memory has no reset logic.
module data_memory
  import data_memory_pkg::*;
#(
  parameter  int unsigned WIDTH   = 32,
  parameter  int unsigned SIZE    = 16,
  localparam int unsigned LOGSIZE = $clog2(SIZE)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [2:0]         funct3,
  input  logic [LOGSIZE+1:0] addr,
  input  logic [WIDTH-1:0]   data_in,
  output logic [WIDTH-1:0]   data_out
);

  logic [WIDTH-1:0]   mem [SIZE];
  logic [LOGSIZE-1:0] word_idx;
  logic [LANES-1:0]   lane_we_c;
  logic [WIDTH-1:0]   wdata_c;
  logic [WORD_W-1:0]  load_val_c;

  assign word_idx = addr[LOGSIZE+1:2];

  // Store lane enables and lane-replicated write data; reset suppresses stores
  always_comb begin
    lane_we_c = '0;
    wdata_c   = '0;
    if (wr_en && !rst) begin
      case (funct3)
        SW: begin
          lane_we_c = 4'b1111;
          wdata_c   = data_in;
        end
        SH: begin
          lane_we_c = addr[1] ? 4'b1100 : 4'b0011;
          wdata_c   = {data_in[15:0], data_in[15:0]};
        end
        SB: begin
          lane_we_c = 4'(4'b0001 << addr[1:0]);
          wdata_c   = {4{data_in[7:0]}};
        end
        default: ;
      endcase
    end
  end

  // Memory array
  always_ff @(posedge clk) begin
`ifdef DMEM_ZERO_INIT_EN
    if (rst) begin
      for (int unsigned i = 0; i < SIZE; i++) begin
        mem[i] <= '0;
      end
    end else begin
`else
    begin
`endif
      for (int unsigned b = 0; b < LANES; b++) begin
        if (lane_we_c[b]) begin
          mem[word_idx][BYTE_W*b +: BYTE_W] <= wdata_c[BYTE_W*b +: BYTE_W];
        end
      end
    end
  end

  load_extend u_load_extend (
    .word     (WORD_W'(mem[word_idx])),
    .byte_off (addr[1:0]),
    .funct3   (funct3),
    .result_c (load_val_c)
  );

  // Load result register; holds during store cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
    end else if (!wr_en) begin
      data_out <= WIDTH'(load_val_c);
    end
  end

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;
  import data_memory_pkg::*;

  localparam int unsigned SIZE  = 16;
  localparam int unsigned NBYTE = SIZE * 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [2:0]  funct3;
  logic [5:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: flat byte-addressed memory plus expected output register
  logic [7:0]  m [NBYTE];
  logic [31:0] exp_out;

  always #5 clk = ~clk;

  data_memory #(.WIDTH(32), .SIZE(SIZE)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .funct3   (funct3),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out)
  );

  function automatic logic [31:0] model_load(input logic [2:0] f, input int a);
    int hb, wb;
    logic [31:0] v;
    hb = a - (a % 2);
    wb = a - (a % 4);
    v  = 32'd0;
    case (f)
      3'b000: begin v = {24'd0, m[a]}; if (m[a][7]) v = v | 32'hFFFF_FF00; end
      3'b001: begin v = {16'd0, m[hb+1], m[hb]}; if (m[hb+1][7]) v = v | 32'hFFFF_0000; end
      3'b010: v = {m[wb+3], m[wb+2], m[wb+1], m[wb]};
      3'b100: v = {24'd0, m[a]};
      3'b101: v = {16'd0, m[hb+1], m[hb]};
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  task automatic model_store(input logic [2:0] f, input int a, input logic [31:0] d);
    int hb, wb;
    hb = a - (a % 2);
    wb = a - (a % 4);
    case (f)
      3'b000: m[a] = d[7:0];
      3'b001: begin m[hb] = d[7:0]; m[hb+1] = d[15:8]; end
      3'b010: for (int k = 0; k < 4; k++) m[wb+k] = d[8*k +: 8];
      default: ;
    endcase
  endtask

  // One clock of traffic; expectation computed from pre-edge model state
  task automatic op(input logic we, input logic [2:0] f, input logic [5:0] a, input logic [31:0] d);
    wr_en = we; funct3 = f; addr = a; data_in = d;
    if (we) model_store(f, int'(a), d);
    else    exp_out = model_load(f, int'(a));
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input logic we, input logic [2:0] f, input logic [5:0] a, input logic [31:0] d);
    rst = 1'b1; wr_en = we; funct3 = f; addr = a; data_in = d;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_out = 32'd0;
`ifdef DMEM_ZERO_INIT_EN
    for (int i = 0; i < NBYTE; i++) m[i] = 8'd0;
`endif
  endtask

  task automatic test_reset();
    do_reset(1'b0, LW, 6'd0, 32'd0);
    do_reset(1'b0, LW, 6'd0, 32'd0);
    tests_run++;
    if (data_out !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_out: got %h expected %h", data_out, 32'd0);
    end
  endtask

  task automatic test_fill();
    for (int w = 0; w < SIZE; w++) op(1'b1, SW, 6'(w * 4), $urandom);
    for (int w = 0; w < SIZE; w++) begin
      op(1'b0, LW, 6'(w * 4), 32'd0);
      tests_run++;
      if (data_out !== exp_out) begin
        tests_failed++;
        $display("FAIL fill_lw[%0d]: got %h expected %h", w, data_out, exp_out);
      end
    end
  endtask

  task automatic test_vectors();
    logic [31:0] want [11];
    logic [31:0] got  [11];
    op(1'b1, SW, 6'h0C, 32'hDEADBEEF);
    op(1'b1, SB, 6'h0C, 32'h00003210);
    op(1'b0, LW, 6'h0C, 32'd0);            got[0] = data_out; want[0] = 32'hDEADBE10;
    op(1'b1, SW, 6'h38, 32'h98765432);
    op(1'b1, SH, 6'h38, 32'h76543210);
    op(1'b0, LB, 6'h38, 32'd0);            got[1] = data_out; want[1] = 32'h00000010;
    op(1'b0, LH, 6'h38, 32'd0);            got[2] = data_out; want[2] = 32'h00003210;
    op(1'b1, SW, 6'h10, 32'h3210F0F0);
    op(1'b0, LW,  6'h10, 32'd0);           got[3] = data_out; want[3] = 32'h3210F0F0;
    op(1'b0, LH,  6'h10, 32'd0);           got[4] = data_out; want[4] = 32'hFFFFF0F0;
    op(1'b0, LHU, 6'h10, 32'd0);           got[5] = data_out; want[5] = 32'h0000F0F0;
    op(1'b0, LB,  6'h10, 32'd0);           got[6] = data_out; want[6] = 32'hFFFFFFF0;
    op(1'b0, LBU, 6'h10, 32'd0);           got[7] = data_out; want[7] = 32'h000000F0;
    op(1'b0, LBU, 6'h13, 32'd0);           got[8] = data_out; want[8] = 32'h00000032;
    op(1'b0, LH,  6'h12, 32'd0);           got[9] = data_out; want[9] = 32'h00003210;
    op(1'b1, SB,  6'h11, 32'h000000AA);
    op(1'b0, LW,  6'h10, 32'd0);           got[10] = data_out; want[10] = 32'h3210AAF0;
    for (int i = 0; i < 11; i++) begin
      tests_run++;
      if (got[i] !== want[i]) begin
        tests_failed++;
        $display("FAIL vector[%0d]: got %h expected %h", i, got[i], want[i]);
      end
    end
  endtask

  task automatic test_invalid();
    op(1'b1, SW, 6'h14, 32'hCAFEF00D);
    op(1'b1, 3'b011, 6'h14, 32'h11111111);
    op(1'b0, LW, 6'h14, 32'd0);
    tests_run++;
    if (data_out !== 32'hCAFEF00D) begin
      tests_failed++;
      $display("FAIL store_f3_011: got %h expected %h", data_out, 32'hCAFEF00D);
    end
    op(1'b0, 3'b110, 6'h14, 32'd0);
    tests_run++;
    if (data_out !== 32'd0) begin
      tests_failed++;
      $display("FAIL load_f3_110: got %h expected %h", data_out, 32'd0);
    end
    // Store cycle must hold previous load result
    op(1'b0, LW, 6'h14, 32'd0);
    op(1'b1, SW, 6'h18, 32'h55AA55AA);
    tests_run++;
    if (data_out !== 32'hCAFEF00D) begin
      tests_failed++;
      $display("FAIL store_hold: got %h expected %h", data_out, 32'hCAFEF00D);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 6'($urandom), $urandom);
      tests_run++;
      if (data_out !== exp_out) begin
        tests_failed++;
        $display("FAIL random[%0d] we=%0b f3=%0d a=%h: got %h expected %h",
                 n, wr_en, funct3, addr, data_out, exp_out);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] lds [5];
    lds[0] = LB; lds[1] = LH; lds[2] = LW; lds[3] = LBU; lds[4] = LHU;
    for (int n = 0; n < 30; n++) begin
      logic [5:0] a;
      a = 6'($urandom);
      op(1'b1, 3'($urandom_range(0, 2)), a, $urandom);
      op(1'b0, lds[$urandom_range(0, 4)], a, 32'd0);
      tests_run++;
      if (data_out !== exp_out) begin
        tests_failed++;
        $display("FAIL b2b[%0d] a=%h: got %h expected %h", n, a, data_out, exp_out);
      end
    end
  endtask

  task automatic test_reset_mid();
    op(1'b1, SW, 6'h20, 32'h12345678);
    op(1'b1, SW, 6'h00, 32'h0BADC0DE);
    op(1'b0, LW, 6'h20, 32'd0);
    tests_run++;
    if (data_out !== 32'h12345678) begin
      tests_failed++;
      $display("FAIL pre_reset: got %h expected %h", data_out, 32'h12345678);
    end
    do_reset(1'b1, SW, 6'h00, 32'hFFFFFFFF);
    tests_run++;
    if (data_out !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_with_store: got %h expected %h", data_out, 32'd0);
    end
    op(1'b0, LW, 6'h00, 32'd0);
    tests_run++;
    if (data_out !== exp_out) begin
      tests_failed++;
      $display("FAIL post_reset_w0: got %h expected %h", data_out, exp_out);
    end
    op(1'b0, LW, 6'h20, 32'd0);
    tests_run++;
    if (data_out !== exp_out) begin
      tests_failed++;
      $display("FAIL post_reset_w8: got %h expected %h", data_out, exp_out);
    end
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; funct3 = 3'd0; addr = 6'd0; data_in = 32'd0;
    exp_out = 32'd0;
    for (int i = 0; i < NBYTE; i++) m[i] = 8'd0;
    @(posedge clk); #1;
    test_reset();
    test_fill();
    test_vectors();
    test_invalid();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
